seq_alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the sequencer ALU. Executes push, add, sub and multiply with fixed, equal latency for all ops, so results leave in issue order.
- Adds a valid/ready handshake with whole-pipe backpressure, an optional unsigned-saturation mode, and an overflow flag.
- Sits between the sequencer register file (operand source) and the register write-back path (result sink).

---
 rtl/seq_definitions.sv | 10 +
 rtl/seq_mul_pipe.sv | 35 +++
 rtl/seq_alu_pipe.sv | 76 +++++++
 tb/tb_seq_alu_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_definitions.sv
// seq_definitions: opcodes and default widths shared by the sequencer ALU blocks
package seq_definitions;
  localparam int alu_width    = 8;
  localparam int seq_im_width = 4;
  localparam int seq_op_width = 2;
  localparam logic [seq_op_width-1:0] seq_op_push  = 2'd0;
  localparam logic [seq_op_width-1:0] seq_op_add   = 2'd1;
  localparam logic [seq_op_width-1:0] seq_op_sub   = 2'd2;
  localparam logic [seq_op_width-1:0] seq_op_multi = 2'd3;
endpackage

// File: rtl/seq_mul_pipe.sv
// seq_mul_pipe: unsigned multiplier spread over LAT enabled register stages
module seq_mul_pipe
  import seq_definitions::*;
#(
  parameter int ALU_WIDTH = alu_width,
  parameter int LAT       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [ALU_WIDTH-1:0] i_a,
  input  logic [ALU_WIDTH-1:0] i_b,
  output logic [ALU_WIDTH-1:0] o_lo,
  output logic                 o_ovf
);
  logic [2*ALU_WIDTH-1:0] w_prod;
  logic [ALU_WIDTH-1:0]   r_lo [LAT];
  logic [LAT-1:0]         r_ovf;
  // the product is formed in front of the stage chain so retiming can balance it across the stages
  assign w_prod = {{ALU_WIDTH{1'b0}}, i_a} * {{ALU_WIDTH{1'b0}}, i_b};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ovf <= '0;
      for (int i = 0; i < LAT; i++) r_lo[i] <= '0;
    end else if (i_en) begin
      r_lo[0]  <= w_prod[ALU_WIDTH-1:0];
      r_ovf[0] <= |w_prod[2*ALU_WIDTH-1:ALU_WIDTH];
      for (int i = 1; i < LAT; i++) begin
        r_lo[i]  <= r_lo[i-1];
        r_ovf[i] <= r_ovf[i-1];
      end
    end
  assign o_lo  = r_lo[LAT-1];
  assign o_ovf = r_ovf[LAT-1];
endmodule

// File: rtl/seq_alu_pipe.sv
// seq_alu_pipe: fixed-latency pipelined push/add/sub/mul ALU with valid/ready and optional saturation
module seq_alu_pipe
  import seq_definitions::*;
#(
  parameter int ALU_WIDTH = alu_width,
  parameter int IM_WIDTH  = seq_im_width,
  parameter int OP_WIDTH  = seq_op_width,
  parameter int LAT       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [OP_WIDTH-1:0]  i_op,
  input  logic [ALU_WIDTH-1:0] i_data_a,
  input  logic [ALU_WIDTH-1:0] i_data_b,
  input  logic [IM_WIDTH-1:0]  i_const,
  input  logic                 i_sat,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ALU_WIDTH-1:0] o_data,
  output logic                 o_ovf
);
  localparam int L = LAT - 1;
  logic                 w_stall, w_en, w_ovf, w_mul_ovf;
  logic [ALU_WIDTH:0]   w_sum, w_dif;
  logic [ALU_WIDTH-1:0] w_push, w_res, w_mul_lo;
  logic [LAT-1:0]       r_vld, r_ovf, r_mul, r_sat;
  logic [ALU_WIDTH-1:0] r_data [LAT];
  assign w_stall = r_vld[L] && !i_ready;
  assign w_en    = !w_stall;
  assign o_ready = w_en;
  assign w_sum   = {1'b0, i_data_a} + {1'b0, i_data_b};
  assign w_dif   = {1'b0, i_data_a} - {1'b0, i_data_b};
  assign w_push  = ALU_WIDTH'({i_data_a, i_const});
  always_comb begin
    w_ovf = (i_op == seq_op_add) ? w_sum[ALU_WIDTH] :
            (i_op == seq_op_sub) ? w_dif[ALU_WIDTH] : 1'b0;
    w_res = (i_op == seq_op_add) ? ((i_sat && w_ovf) ? '1 : w_sum[ALU_WIDTH-1:0]) :
            (i_op == seq_op_sub) ? ((i_sat && w_ovf) ? '0 : w_dif[ALU_WIDTH-1:0]) : w_push;
  end
  seq_mul_pipe #(.ALU_WIDTH(ALU_WIDTH), .LAT(LAT)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_en),
    .i_a   (i_data_a),
    .i_b   (i_data_b),
    .o_lo  (w_mul_lo),
    .o_ovf (w_mul_ovf)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_vld <= '0;
      r_ovf <= '0;
      r_mul <= '0;
      r_sat <= '0;
      for (int i = 0; i < LAT; i++) r_data[i] <= '0;
    end else if (w_en) begin
      r_vld[0]  <= i_valid;
      r_data[0] <= w_res;
      r_ovf[0]  <= w_ovf;
      r_mul[0]  <= i_op == seq_op_multi;
      r_sat[0]  <= i_sat;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
        r_ovf[i]  <= r_ovf[i-1];
        r_mul[i]  <= r_mul[i-1];
        r_sat[i]  <= r_sat[i-1];
      end
    end
  // mul results bypass the data stages and take saturation from the op's own delayed i_sat
  assign o_valid = r_vld[L];
  assign o_data  = r_mul[L] ? ((r_sat[L] && w_mul_ovf) ? '1 : w_mul_lo) : r_data[L];
  assign o_ovf   = r_mul[L] ? w_mul_ovf : r_ovf[L];
endmodule

// File: tb/tb_seq_alu_pipe.sv
// tb_seq_alu_pipe: directed and random scoreboard checks of seq_alu_pipe at default parameters
module tb_seq_alu_pipe;
  import seq_definitions::*;
  typedef struct {
    logic [7:0] data;
    logic       ovf;
    string      tag;
  } exp_t;
  logic       clk = 0;
  logic       rst;
  logic       i_valid, o_ready, i_sat, o_valid, i_ready, o_ovf;
  logic [1:0] i_op;
  logic [7:0] i_data_a, i_data_b, o_data;
  logic [3:0] i_const;
  exp_t       sb[$];
  exp_t       e;
  int         ret_q[$];
  int         compared = 0;
  int         mism = 0;
  int         cyc = 0;
  logic [8:0] m;

  seq_alu_pipe dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_const(i_const), .i_sat(i_sat),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (rst && o_valid && i_ready) begin
      compared++;
      assert (sb.size() > 0) else begin
        mism++;
        $error("FAIL unexpected: got data=%h ovf=%b, required no result", o_data, o_ovf);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ret_q.push_back(cyc);
        compared++;
        assert ({o_ovf, o_data} === {e.ovf, e.data}) else begin
          mism++;
          $error("FAIL %s: got data=%h ovf=%b, required data=%h ovf=%b", e.tag, o_data, o_ovf, e.data, e.ovf);
        end
      end
    end

  function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] c, input logic sat);
    int r;
    case (op)
      seq_op_push: return {1'b0, a[3:0], c};
      seq_op_add: begin
        r = int'(a) + int'(b);
        return (r > 255) ? {1'b1, sat ? 8'hFF : 8'(r)} : {1'b0, 8'(r)};
      end
      seq_op_sub: begin
        r = int'(a) - int'(b);
        return (r < 0) ? {1'b1, sat ? 8'h00 : 8'(r)} : {1'b0, 8'(r)};
      end
      default: begin
        r = int'(a) * int'(b);
        return (r > 255) ? {1'b1, sat ? 8'hFF : 8'(r)} : {1'b0, 8'(r)};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] req);
    compared++;
    assert (got === req) else begin
      mism++;
      $error("FAIL %s: got %h, required %h", tag, got, req);
    end
  endtask

  // drives one op, waits out any stall, records its expected result on acceptance
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                      input logic sat, input logic [7:0] ed, input logic eo, input string tag);
    int t = 0;
    i_valid = 1; i_op = op; i_data_a = a; i_data_b = b; i_const = c; i_sat = sat;
    @(negedge clk);
    while (!o_ready && t < 20) begin
      @(posedge clk); #1 i_ready = 1;
      @(negedge clk);
      t++;
    end
    check({tag, "_accept"}, {8'h0, o_ready}, 9'h1);
    sb.push_back('{ed, eo, tag});
    @(posedge clk); #1 i_valid = 0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    #1 check({tag, "_drain"}, 9'(sb.size()), 9'h0);
  endtask

  initial begin
    rst = 0; i_valid = 0; i_ready = 1; i_op = 0; i_data_a = 0; i_data_b = 0; i_const = 0; i_sat = 0;
    #12 check("reset_out", {o_ovf, o_data}, 9'h0);
    check("reset_valid", {8'h0, o_valid}, 9'h0);
    rst = 1;
    #1 check("reset_ready", {8'h0, o_ready}, 9'h1);
    @(posedge clk); #1;

    send(seq_op_add, 8'h70, 8'h20, 4'h0, 0, 8'h90, 0, "add_lat");
    check("lat_early", {8'h0, o_valid}, 9'h0);
    @(posedge clk); #1 check("lat_valid", {8'h0, o_valid}, 9'h1);
    check("lat_data", {o_ovf, o_data}, 9'h090);
    drain("lat");

    send(seq_op_add, 8'hF0, 8'h20, 4'h0, 0, 8'h10, 1, "add_wrap");
    send(seq_op_add, 8'hF0, 8'h20, 4'h0, 1, 8'hFF, 1, "add_sat");
    send(seq_op_sub, 8'h05, 8'h07, 4'h0, 0, 8'hFE, 1, "sub_wrap");
    send(seq_op_sub, 8'h05, 8'h07, 4'h0, 1, 8'h00, 1, "sub_sat");
    send(seq_op_multi, 8'h0F, 8'h11, 4'h0, 0, 8'hFF, 0, "mul_max");
    send(seq_op_multi, 8'h10, 8'h10, 4'h0, 0, 8'h00, 1, "mul_wrap");
    send(seq_op_multi, 8'h10, 8'h10, 4'h0, 1, 8'hFF, 1, "mul_sat");
    send(seq_op_push, 8'h3C, 8'h00, 4'h5, 1, 8'hC5, 0, "push");
    drain("ops");

    ret_q.delete();
    send(seq_op_multi, 8'h06, 8'h07, 4'h0, 0, 8'h2A, 0, "str_mul");
    send(seq_op_add, 8'h11, 8'h22, 4'h0, 0, 8'h33, 0, "str_add");
    send(seq_op_push, 8'h01, 8'h00, 4'h9, 0, 8'h19, 0, "str_push");
    drain("stream");
    check("stream_cnt", 9'(ret_q.size()), 9'd3);
    if (ret_q.size() == 3) begin
      check("stream_gap1", 9'(ret_q[1] - ret_q[0]), 9'd1);
      check("stream_gap2", 9'(ret_q[2] - ret_q[1]), 9'd1);
    end

    ret_q.delete();
    send(seq_op_add, 8'h01, 8'h01, 4'h0, 0, 8'h02, 0, "stall_a");
    send(seq_op_multi, 8'h05, 8'h05, 4'h0, 0, 8'h19, 0, "stall_b");
    send(seq_op_sub, 8'h09, 8'h03, 4'h0, 0, 8'h06, 0, "stall_c");
    i_ready = 0;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", {8'h0, o_ready}, 9'h0);
      check("stall_hold", {o_ovf, o_data}, 9'h019);
    end
    @(posedge clk); #1 i_ready = 1;
    drain("stall");
    check("stall_cnt", 9'(ret_q.size()), 9'd3);

    send(seq_op_multi, 8'h03, 8'h04, 4'h0, 0, 8'h0C, 0, "rst_a");
    send(seq_op_add, 8'h01, 8'h02, 4'h0, 0, 8'h03, 0, "rst_b");
    #2 rst = 0;
    #1 check("rst_async", {7'h0, o_valid, o_ovf}, 9'h0);
    check("rst_data", {1'b0, o_data}, 9'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1;
    repeat (3) begin
      @(negedge clk);
      check("no_stale", {8'h0, o_valid}, 9'h0);
    end
    @(posedge clk); #1;
    send(seq_op_sub, 8'h09, 8'h04, 4'h0, 0, 8'h05, 0, "post_rst");
    check("post_rst_early", {8'h0, o_valid}, 9'h0);
    @(posedge clk); #1 check("post_rst_lat", {o_valid, o_data}, 9'h105);
    drain("post_rst");

    for (int k = 0; k < 24; k++) begin
      logic [1:0] op;
      logic [7:0] a, b;
      logic [3:0] c;
      logic       s;
      op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
      c = 4'($urandom); s = 1'($urandom);
      i_ready = ($urandom_range(0, 2) != 0);
      m = model(op, a, b, c, s);
      send(op, a, b, c, s, m[7:0], m[8], "rand");
    end
    i_ready = 1;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
